// File: rtl/clock_divider_prog.sv
// Runtime-programmable tick generator: one-cycle tick_o and near-50% clk_o per divisor period.
// New divisors are held pending and only take effect at a period boundary or sync restart.
module clock_divider_prog #(
    parameter int          WIDTH       = 28,
    parameter int unsigned DIV_DEFAULT = 100000000
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             div_load_i,
    output logic             div_ack_o,
    output logic             tick_o,
    output logic             clk_o
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

    logic [WIDTH-1:0] r_cnt, r_div_cur, r_div_pend;
    logic             r_pend, r_tick, r_ack, r_clk;

    logic [WIDTH-1:0] w_load_val, w_new_val;
    logic [WIDTH-1:0] w_cnt_nxt, w_div_nxt, w_dpend_nxt;
    logic             w_have_new, w_wrap;
    logic             w_pend_nxt, w_tick_nxt, w_ack_nxt, w_clk_nxt;

    // Divisors below 2 cannot produce a distinct tick, so they are clamped.
    assign w_load_val = (div_i < WIDTH'(2)) ? WIDTH'(2) : div_i;
    // A load in the same cycle as the boundary beats an older pending value.
    assign w_new_val  = div_load_i ? w_load_val : r_div_pend;
    assign w_have_new = div_load_i | r_pend;
    assign w_wrap     = en_i & (r_cnt == (r_div_cur - WIDTH'(1)));

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div_cur;
        w_dpend_nxt = r_div_pend;
        w_pend_nxt  = r_pend;
        w_tick_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_clk_nxt   = r_clk;

        if (div_load_i) begin
            w_dpend_nxt = w_load_val;
            w_pend_nxt  = 1'b1;
        end

        if (sync_i || w_wrap) begin
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
            if (w_have_new) begin
                w_div_nxt  = w_new_val;
                w_pend_nxt = 1'b0;
                w_ack_nxt  = 1'b1;
            end
        end else if (en_i) begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
        end

        // clk_o follows the post-update phase so it lines up with tick_o.
        if (sync_i)
            w_clk_nxt = 1'b1;
        else if (en_i)
            w_clk_nxt = (w_cnt_nxt < (w_div_nxt >> 1));
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_div_cur  <= DIV_RST;
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
            r_clk      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_nxt;
            r_div_pend <= w_dpend_nxt;
            r_pend     <= w_pend_nxt;
            r_tick     <= w_tick_nxt;
            r_ack      <= w_ack_nxt;
            r_clk      <= w_clk_nxt;
        end
    end

    assign tick_o    = r_tick;
    assign div_ack_o = r_ack;
    assign clk_o     = r_clk;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed plus random stimulus against a period-level reference model of the divider.
module tb_clock_divider_prog;

    localparam int W   = 28;
    localparam int DEF = 10;

    logic         clk_i = 1'b0;
    logic         reset = 1'b0;
    logic         en_i = 1'b0, sync_i = 1'b0, div_load_i = 1'b0;
    logic [W-1:0] div_i = '0;
    logic         div_ack_o, tick_o, clk_o;

    clock_divider_prog #(.WIDTH(W), .DIV_DEFAULT(DEF)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .en_i       (en_i),
        .sync_i     (sync_i),
        .div_i      (div_i),
        .div_load_i (div_load_i),
        .div_ack_o  (div_ack_o),
        .tick_o     (tick_o),
        .clk_o      (clk_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current period, period length, pending divisor.
    int m_pos, m_D, m_pv;
    bit m_pend, m_tick, m_ack, m_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_D = DEF; m_pv = 0; m_pend = 0;
        m_tick = 0; m_ack = 0; m_clk = 0;
    endtask

    task automatic new_period(input bit have_new, input int nv);
        m_tick = 1;
        if (have_new) begin
            m_D = nv; m_pend = 0; m_ack = 1;
        end
    endtask

    task automatic model_step(input bit en, input bit sy, input bit ld, input int dv);
        int  nv;
        bit  hn;
        nv = ld ? ((dv < 2) ? 2 : dv) : m_pv;
        hn = ld || m_pend;
        m_tick = 0; m_ack = 0;
        if (ld) begin m_pv = nv; m_pend = 1; end
        if (sy) begin
            m_pos = 0;
            new_period(hn, nv);
            m_clk = 1;
        end else if (en) begin
            m_pos++;
            if (m_pos == m_D) begin
                m_pos = 0;
                new_period(hn, nv);
            end
            m_clk = (m_pos < m_D / 2);
        end
    endtask

    task automatic cyc(input bit en, input bit sy, input bit ld, input int dv, input string tag);
        en_i = en; sync_i = sy; div_load_i = ld; div_i = W'(dv);
        @(posedge clk_i);
        model_step(en, sy, ld, dv);
        #1;
        chk({tag, ".tick"}, tick_o, m_tick);
        chk({tag, ".ack"}, div_ack_o, m_ack);
        chk({tag, ".clk"}, clk_o, m_clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, ".rst_tick"}, tick_o, 0);
        chk({tag, ".rst_ack"}, div_ack_o, 0);
        chk({tag, ".rst_clk"}, clk_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        reset = 1'b1;
    endtask

    // Load a divisor and run until it is acknowledged.
    task automatic set_div(input int dv, input string tag);
        int n;
        cyc(1, 0, 1, dv, tag);
        n = 0;
        while (!m_ack && n < 40) begin cyc(1, 0, 0, 0, tag); n++; end
        chk({tag, ".ack_seen"}, m_ack, 1);
    endtask

    task automatic run_to_pos(input int p, input string tag);
        int n;
        n = 0;
        while (m_pos != p && n < 40) begin cyc(1, 0, 0, 0, tag); n++; end
        chk({tag, ".reach_pos"}, m_pos, p);
    endtask

    initial begin
        int first, highs, gap, n;
        model_reset();
        do_reset("t0");

        // Default divisor: first tick on edge 10, clk_o 5 high / 5 low.
        first = 0; highs = 0;
        for (int i = 1; i <= 35; i++) begin
            cyc(1, 0, 0, 0, "t1");
            if (tick_o && first == 0) first = i;
            if (i >= 11 && i <= 20 && clk_o) highs++;
        end
        chk("t1.first_tick_edge", first, 10);
        chk("t1.high_cycles", highs, 5);
        do_reset("t1mid");

        // Divisor 7.
        set_div(7, "t2");
        for (int i = 0; i < 21; i++) cyc(1, 0, 0, 0, "t2run");

        // Load 4 mid-period of a 10 period: applied at the boundary, next tick 4 later.
        set_div(10, "t3a");
        run_to_pos(3, "t3b");
        cyc(1, 0, 1, 4, "t3load");
        n = 0;
        while (!div_ack_o && n < 20) begin cyc(1, 0, 0, 0, "t3w"); n++; end
        chk("t3.ack_seen", div_ack_o, 1);
        chk("t3.tick_with_ack", tick_o, 1);
        gap = 0;
        do begin cyc(1, 0, 0, 0, "t3g"); gap++; end while (!tick_o && gap < 12);
        chk("t3.gap", gap, 4);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, "t3run");

        // Clamping of 0 and 1.
        set_div(0, "t4a");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, "t4a_run");
        set_div(1, "t4b");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, "t4b_run");

        // Pause for 5 cycles mid-period.
        set_div(10, "t5a");
        run_to_pos(6, "t5b");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, "t5pause");
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, "t5run");

        // Sync restarts with a same-cycle load, enabled then paused.
        run_to_pos(6, "t6a");
        cyc(1, 1, 1, 5, "t6sync_en");
        chk("t6.sync_ack", div_ack_o, 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, "t6run");
        cyc(0, 1, 1, 9, "t6sync_dis");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "t6hold");
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, "t6run2");

        // Reset discards a pending divisor.
        cyc(0, 0, 1, 3, "t7load");
        do_reset("t7");
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, "t7run");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 15) == 0,
                int'($urandom % 13), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
